// File: rtl/iagc_telemetry_framer_if.sv
// Byte-stream handshake between the telemetry framer and the UART transmitter.
interface iagc_telemetry_framer_if;
  logic [7:0] o_byte;
  logic       o_byteValid;
  logic       i_byteReady;

  modport master (output o_byte, output o_byteValid, input i_byteReady);
  modport slave  (input o_byte, input o_byteValid, output i_byteReady);
endinterface

// File: rtl/iagc_telemetry_framer.sv
// Periodic telemetry framer: snapshots channel fields plus IAGC status and emits
// SYNC, HEADER{seq,status}, payload (channel 0 first, MSB byte first) and a checksum.
module iagc_telemetry_framer #(
  parameter int          CHANNELS         = 4,
  parameter int          FIELD_SIZE       = 16,
  parameter int          IAGC_STATUS_SIZE = 4,
  parameter int          UART_DATA_SIZE   = 8,
  parameter int          FRAME_PERIOD     = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [IAGC_STATUS_SIZE-1:0]    i_iagcStatus,
  input  logic [CHANNELS*FIELD_SIZE-1:0] i_fields,
  input  logic                           i_fieldsValid,
  input  logic                           i_enable,
  iagc_telemetry_framer_if.master        tx,
  output logic                           o_busy,
  output logic                           o_frameDone,
  output logic [7:0]                     o_overrunCount
);

  localparam int BW = UART_DATA_SIZE;
  localparam int FB = FIELD_SIZE / BW;
  localparam int PB = CHANNELS * FB;
  localparam int PW = PB * BW;
  localparam int TW = $clog2(FRAME_PERIOD);
  localparam int CW = $clog2(PB + 1);
  localparam logic [TW-1:0] T_LAST = TW'(FRAME_PERIOD - 1);
  localparam logic [CW-1:0] C_LAST = CW'(PB);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_HEADER, ST_PAYLOAD, ST_CHECKSUM
  } state_t;

  state_t                      state_r, state_nx_s;
  logic [TW-1:0]               timer_r, timer_nx_s;
  logic [CHANNELS*FIELD_SIZE-1:0] shadow_r, snapshot_s;
  logic [PW-1:0]               buf_r, buf_nx_s, payload_s;
  logic [CW-1:0]               cnt_r, cnt_nx_s;
  logic [3:0]                  seq_r, seq_nx_s, status_r, status_nx_s;
  logic [7:0]                  csum_r, csum_nx_s, byte_r, byte_nx_s;
  logic [7:0]                  overrun_r, overrun_nx_s, header_s, top_s;
  logic                        valid_r, valid_nx_s, busy_r, busy_nx_s;
  logic                        done_r, done_nx_s, tick_s, xfer_s;

  assign snapshot_s = i_fieldsValid ? i_fields : shadow_r;
  assign header_s   = {seq_r, status_r};
  assign top_s      = buf_r[PW-1 -: BW];
  assign tick_s     = i_enable & (timer_r == T_LAST);
  assign xfer_s     = valid_r & tx.i_byteReady;

  // Reorder the snapshot so that the next payload byte always sits at the top of the buffer
  always_comb begin
    payload_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int b = 0; b < FB; b++) begin
        payload_s[PW-1-(c*FB+b)*BW -: BW] = snapshot_s[c*FIELD_SIZE+(FB-1-b)*BW +: BW];
      end
    end
  end

  // Next-state, timer, overrun and output-register logic
  always_comb begin
    state_nx_s   = state_r;
    buf_nx_s     = buf_r;
    cnt_nx_s     = cnt_r;
    seq_nx_s     = seq_r;
    status_nx_s  = status_r;
    csum_nx_s    = csum_r;
    byte_nx_s    = byte_r;
    valid_nx_s   = valid_r;
    busy_nx_s    = busy_r;
    done_nx_s    = 1'b0;
    overrun_nx_s = overrun_r;

    if (!i_enable) begin
      timer_nx_s = '0;
    end else if (timer_r == T_LAST) begin
      timer_nx_s = '0;
    end else begin
      timer_nx_s = timer_r + TW'(1);
    end

    if (tick_s && (state_r != ST_IDLE) && (overrun_r != 8'hFF)) begin
      overrun_nx_s = overrun_r + 8'd1;
    end else begin
      overrun_nx_s = overrun_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_nx_s  = ST_SYNC;
          buf_nx_s    = payload_s;
          status_nx_s = i_iagcStatus[3:0];
          csum_nx_s   = 8'h00;
          byte_nx_s   = SYNC_BYTE;
          valid_nx_s  = 1'b1;
          busy_nx_s   = 1'b1;
        end else begin
          state_nx_s  = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (xfer_s) begin
          state_nx_s = ST_HEADER;
          byte_nx_s  = header_s;
          csum_nx_s  = csum_r + header_s;
        end else begin
          state_nx_s = ST_SYNC;
        end
      end
      ST_HEADER: begin
        if (xfer_s) begin
          state_nx_s = ST_PAYLOAD;
          byte_nx_s  = top_s;
          csum_nx_s  = csum_r + top_s;
          buf_nx_s   = buf_r << BW;
          cnt_nx_s   = CW'(1);
        end else begin
          state_nx_s = ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        // cnt_r counts payload bytes already presented, including the one on the bus
        if (xfer_s && (cnt_r == C_LAST)) begin
          state_nx_s = ST_CHECKSUM;
          byte_nx_s  = csum_r;
        end else if (xfer_s) begin
          byte_nx_s  = top_s;
          csum_nx_s  = csum_r + top_s;
          buf_nx_s   = buf_r << BW;
          cnt_nx_s   = cnt_r + CW'(1);
        end else begin
          state_nx_s = ST_PAYLOAD;
        end
      end
      ST_CHECKSUM: begin
        if (xfer_s) begin
          state_nx_s = ST_IDLE;
          valid_nx_s = 1'b0;
          busy_nx_s  = 1'b0;
          done_nx_s  = 1'b1;
          seq_nx_s   = seq_r + 4'd1;
        end else begin
          state_nx_s = ST_CHECKSUM;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        valid_nx_s = 1'b0;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r   <= ST_IDLE;
      timer_r   <= '0;
      shadow_r  <= '0;
      buf_r     <= '0;
      cnt_r     <= '0;
      seq_r     <= 4'd0;
      status_r  <= 4'd0;
      csum_r    <= 8'h00;
      byte_r    <= 8'h00;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 8'h00;
    end else begin
      state_r   <= state_nx_s;
      timer_r   <= timer_nx_s;
      shadow_r  <= i_fieldsValid ? i_fields : shadow_r;
      buf_r     <= buf_nx_s;
      cnt_r     <= cnt_nx_s;
      seq_r     <= seq_nx_s;
      status_r  <= status_nx_s;
      csum_r    <= csum_nx_s;
      byte_r    <= byte_nx_s;
      valid_r   <= valid_nx_s;
      busy_r    <= busy_nx_s;
      done_r    <= done_nx_s;
      overrun_r <= overrun_nx_s;
    end
  end

  assign tx.o_byte      = byte_r;
  assign tx.o_byteValid = valid_r;
  assign o_busy         = busy_r;
  assign o_frameDone    = done_r;
  assign o_overrunCount = overrun_r;

endmodule

// File: doc/iagc_telemetry_framer.md
# iagc_telemetry_framer

Parametrised telemetry framer for the IAGC datapath; successor to the fixed-format logger path. Once every `FRAME_PERIOD` clocks it snapshots `CHANNELS` amplitude/ratio fields plus the IAGC status, and serialises them as a framed byte stream with sync, sequence, payload and checksum. The byte stream leaves on a valid/ready handshake toward the UART transmitter. The block sits between the processor outputs and the UART TX, on `clock0`.

## Interface
- `CHANNELS`, 4, number of fields per frame (1..16)
- `FIELD_SIZE`, 16, bits per field; multiple of 8
- `IAGC_STATUS_SIZE`, 4, width of IAGC status; low 4 bits are framed
- `UART_DATA_SIZE`, 8, byte width; fixed at 8
- `FRAME_PERIOD`, 1_000_000, clocks between frame ticks (≥ 2)
- `SYNC_BYTE`, 8'hA5, first byte of every frame

Ports:
- `i_clock` in 1: system clock. One clock; reset is synchronous and active-high.
- `i_reset` in 1: synchronous, active-high reset.
- `i_iagcStatus` in IAGC_STATUS_SIZE: current global FSM status.
- `i_fields` in CHANNELS*FIELD_SIZE: channel 0 in the LSBs.
- `i_fieldsValid` in 1: capture `i_fields` into the shadow register.
- `i_enable` in 1: frame timer runs while high.
- `o_byte` out 8: current frame byte.
- `o_byteValid` out 1: `o_byte` is valid.
- `i_byteReady` in 1: sink accepts the byte.
- `o_busy` out 1: a frame is in progress.
- `o_frameDone` out 1: one-cycle pulse per completed frame.
- `o_overrunCount` out 8: number of skipped frames; saturates at 255.

## Operation
- Frame layout: `SYNC_BYTE`, HEADER = {seq[3:0], status[3:0]}, payload, CHECKSUM.
  - Payload order: channel 0 first, each field MSB byte first.
  - Frame length: 3 + CHANNELS*FIELD_SIZE/8 bytes.
- CHECKSUM is the mod-256 sum of HEADER and all payload bytes; SYNC is excluded.
- Shadow register: loads `i_fields` on every cycle where `i_fieldsValid` is high. Reset value 0.
- Frame timer:
  - Counts 0..FRAME_PERIOD-1 while `i_enable` is high, and wraps.
  - Held at 0 while `i_enable` is low.
  - Tick occurs in the cycle where count == FRAME_PERIOD-1 and `i_enable` is high.
- On a tick while IDLE:
  - Frame buffer loads `i_fieldsValid ? i_fields : shadow`, so a same-cycle update is included.
  - `i_iagcStatus[3:0]` and seq are latched.
  - Checksum accumulator clears.
  - State moves to SYNC.
- On a tick while not IDLE: no new frame starts. `o_overrunCount` increments, saturating at 255.
- States and transitions:
  - IDLE → SYNC on a tick.
  - SYNC → HEADER on transfer.
  - HEADER → PAYLOAD on transfer.
  - PAYLOAD → CHECKSUM on transfer of the last payload byte.
  - CHECKSUM → IDLE on transfer.
- Transfer = `o_byteValid & i_byteReady` in the same cycle.
- While `o_byteValid` is high, `o_byte` is held stable until transfer; valid never drops without a transfer.
- seq increments (wraps 15→0) when CHECKSUM transfers; first frame after reset carries seq 0.
- `i_enable` falling mid-frame does not abort: the current frame completes and the timer then holds at 0.
- The frame buffer is isolated from the shadow register; `i_fieldsValid` during a frame does not alter the bytes in flight.

## Timing
- Reset values: `o_byte`=0, `o_byteValid`=0, `o_busy`=0, `o_frameDone`=0, `o_overrunCount`=0. Seq, timer, shadow and frame buffer are all 0.
- Reset asserted mid-frame: `o_byteValid` is low in the cycle after reset is sampled, and the frame is discarded.
- Tick at cycle T: `o_byteValid`=1 with `o_byte`=SYNC and `o_busy`=1 at T+1.
- After a transfer at cycle T, the next byte is valid at T+1; with `i_byteReady` held high, output is one byte per clock.
- Minimum frame duration: 3 + CHANNELS*FIELD_SIZE/8 cycles.
- `o_frameDone` pulses at T+1 after the CHECKSUM transfer at T; `o_busy` falls at the same cycle.
- A tick in the same cycle as the CHECKSUM transfer counts as an overrun; the state is still not IDLE.
- All outputs are registered.

## Test plan
- CHANNELS=2, FIELD_SIZE=16, FRAME_PERIOD=64; `i_fields`={16'hABCD,16'h1234}, status 4'h3, ready always high.
  - Required bytes: A5, 03, 12, 34, AB, CD, C1.
  - `o_frameDone` pulses once.
  - The next frame has header 13.
- Same setup with `i_byteReady` toggling every other cycle: byte sequence identical; `o_byte` stable across every stalled cycle.
- `i_byteReady` low for 200 cycles after SYNC is presented: `o_overrunCount`=3; frame then completes intact with its original snapshot.
- `i_fieldsValid` pulse with new data during a frame: the current frame is unchanged; the next frame carries the new data. A pulse in the tick cycle is included in the frame that starts.
- 17 consecutive frames: headers cycle seq 0..15, then 0 again.
- Reset asserted after the third byte: `o_byteValid` low the next cycle; after reset, the first frame has seq 0 and all payload bytes are 00.
